mem_read_arbiter: RTL and testbench

//  Shares one read-only memory bus between the fetch unit (master 0, instruction) and the

---
 rtl/mem_read_arbiter_pkg.sv | 22 ++
 rtl/mem_read_arbiter_if.sv | 15 +
 rtl/mem_read_arbiter_pick.sv | 41 ++++
 rtl/mem_read_arbiter.sv | 111 +++++++++++
 tb/tb_mem_read_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the two-master memory read arbiter.
// The arbitration mode is selected by the MEM_ARB_ROUND_ROBIN_EN macro.
package mem_read_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int STARVE_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    ARB_M_IFU = 1'b0,
    ARB_M_LSU = 1'b1
  } arb_master_t;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (v == {STARVE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// One read port: a requester (master modport) and the side serving it (slave modport).
// Handshake: re is raised with sel/addr and held until the cycle ack=1; that cycle
// completes the read and data is valid only while ack=1. No ack ever arrives without re.
interface mem_read_arbiter_if #(
  parameter int XLEN = 32
);
  logic              re;
  logic [XLEN/8-1:0] sel;
  logic [XLEN-1:0]   addr;
  logic              ack;
  logic [XLEN-1:0]   data;

  modport master (output re, sel, addr, input ack, data);
  modport slave  (input re, sel, addr, output ack, data);
endinterface

// File: rtl/mem_read_arbiter_pick.sv
// Combinational winner select for the read arbiter.
// Round robin when MEM_ARB_ROUND_ROBIN_EN is defined, else fixed priority with starvation guard.
module mem_arb_pick
  import mem_read_arbiter_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic                m0_re,
  input  logic                m1_re,
  input  arb_master_t         rr_last,
  input  logic [STARVE_W-1:0] starve_cnt,
  output arb_master_t         winner
);

  localparam logic [STARVE_W-1:0] MAX_STARVE_W = STARVE_W'(MAX_STARVE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [STARVE_W-1:0] unused_starve_cnt;
  assign unused_starve_cnt = starve_cnt;
`else
  arb_master_t unused_rr_last;
  assign unused_rr_last = rr_last;
`endif

  always_comb begin
    winner = ARB_M_IFU;
    if (m0_re && !m1_re) begin
      winner = ARB_M_IFU;
    end else if (m1_re && !m0_re) begin
      winner = ARB_M_LSU;
    end else if (m0_re && m1_re) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = (rr_last == ARB_M_LSU) ? ARB_M_IFU : ARB_M_LSU;
`else
      // Data normally wins ties; fetch is forced ahead once it has lost too often.
      winner = (starve_cnt >= MAX_STARVE_W) ? ARB_M_IFU : ARB_M_LSU;
`endif
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one read-only memory bus between fetch (m0) and load/store (m1), one read in flight.
// Tie-break mode is selected by MEM_ARB_ROUND_ROBIN_EN (undefined: fixed priority to m1).
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int XLEN       = mem_read_arbiter_pkg::XLEN,
  parameter int MAX_STARVE = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_read_arbiter_if.slave   m0,
  mem_read_arbiter_if.slave   m1,
  mem_read_arbiter_if.master  s,
  output logic                grant,
  output logic                busy,
  output arb_state_t          dbg_state,
  output logic [STARVE_W-1:0] dbg_starve_cnt
);

  arb_state_t          state_q, state_d;
  logic                s_re_q, s_re_d;
  logic [XLEN/8-1:0]   s_sel_q, s_sel_d;
  logic [XLEN-1:0]     s_addr_q, s_addr_d;
  arb_master_t         grant_q, grant_d;
  arb_master_t         rr_last_q, rr_last_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  arb_master_t         winner;

  mem_arb_pick #(
    .MAX_STARVE (MAX_STARVE)
  ) u_pick (
    .m0_re      (m0.re),
    .m1_re      (m1.re),
    .rr_last    (rr_last_q),
    .starve_cnt (starve_q),
    .winner     (winner)
  );

  always_comb begin
    state_d   = state_q;
    s_re_d    = s_re_q;
    s_sel_d   = s_sel_q;
    s_addr_d  = s_addr_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    starve_d  = starve_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0.re || m1.re) begin
          state_d   = ARB_BUSY;
          s_re_d    = 1'b1;
          grant_d   = winner;
          rr_last_d = winner;
          s_sel_d   = (winner == ARB_M_LSU) ? m1.sel  : m0.sel;
          s_addr_d  = (winner == ARB_M_LSU) ? m1.addr : m0.addr;
`ifndef MEM_ARB_ROUND_ROBIN_EN
          if (winner == ARB_M_IFU) begin
            starve_d = '0;
          end else if (m0.re) begin
            starve_d = sat_inc(starve_q);
          end
`endif
        end
      end
      ARB_BUSY: begin
        // Request registers stay frozen until the slave completes.
        if (s.ack) begin
          state_d = ARB_IDLE;
          s_re_d  = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      s_re_q    <= 1'b0;
      s_sel_q   <= '0;
      s_addr_q  <= '0;
      grant_q   <= ARB_M_IFU;
      rr_last_q <= ARB_M_LSU;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      s_re_q    <= s_re_d;
      s_sel_q   <= s_sel_d;
      s_addr_q  <= s_addr_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      starve_q  <= starve_d;
    end
  end

  // A stray s_ack while idle must not reach either master.
  assign m0.ack  = (state_q == ARB_BUSY) && s.ack && (grant_q == ARB_M_IFU);
  assign m1.ack  = (state_q == ARB_BUSY) && s.ack && (grant_q == ARB_M_LSU);
  assign m0.data = s.data;
  assign m1.data = s.data;

  assign s.re   = s_re_q;
  assign s.sel  = s_sel_q;
  assign s.addr = s_addr_q;

  assign grant          = grant_q;
  assign busy           = (state_q == ARB_BUSY);
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed scenarios plus randomized rounds
// checked against a rule-level arbitration model (honours MEM_ARB_ROUND_ROBIN_EN).
module tb_mem_read_arbiter;
  import mem_read_arbiter_pkg::*;

  localparam int XLEN       = 32;
  localparam int SW         = XLEN / 8;
  localparam int MAX_STARVE = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          grant;
  logic          busy;
  arb_state_t    dbg_state;
  logic [3:0]    dbg_starve_cnt;

  mem_read_arbiter_if #(.XLEN(XLEN)) m0_if ();
  mem_read_arbiter_if #(.XLEN(XLEN)) m1_if ();
  mem_read_arbiter_if #(.XLEN(XLEN)) s_if ();

  mem_read_arbiter #(
    .XLEN       (XLEN),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m0             (m0_if),
    .m1             (m1_if),
    .s              (s_if),
    .grant          (grant),
    .busy           (busy),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];

  // reference model state: consecutive tie losses of m0, and the last granted master
  int m_starve  = 0;
  int m_rr_last = 1;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return (m_rr_last == 1) ? 0 : 1;
`else
    return (m_starve >= MAX_STARVE) ? 0 : 1;
`endif
  endfunction

  task automatic model_grant(input int w, input bit both);
    m_rr_last = w;
`ifndef MEM_ARB_ROUND_ROBIN_EN
    if (w == 0) m_starve = 0;
    else if (both && m_starve < 15) m_starve++;
`endif
  endtask

  task automatic model_reset();
    m_starve  = 0;
    m_rr_last = 1;
  endtask

  // driver: one complete read round, called just after a posedge with the DUT idle
  task automatic do_txn(input bit r0, input bit r1, input logic [XLEN-1:0] a0,
                        input logic [XLEN-1:0] a1, input int lat, input bit mutate);
    int w;
    logic [SW-1:0]   sel0, sel1, exp_sel;
    logic [XLEN-1:0] exp_addr, rdata;
    w    = model_pick(r0, r1);
    sel0 = SW'($urandom);
    sel1 = SW'($urandom);
    m0_if.re = r0; m0_if.addr = a0; m0_if.sel = sel0;
    m1_if.re = r1; m1_if.addr = a1; m1_if.sel = sel1;
    exp_addr = (w == 1) ? a1 : a0;
    exp_sel  = (w == 1) ? sel1 : sel0;
    exp_q.push_back(exp_addr);
    #1;
    check("idle_before_req", XLEN'(busy), XLEN'(0));
    @(posedge clk); #1;
    model_grant(w, r0 && r1);
    check("s_re_issued", XLEN'(s_if.re), XLEN'(1));
    check("s_addr_issued", s_if.addr, exp_q.pop_front());
    check("s_sel_issued", XLEN'(s_if.sel), XLEN'(exp_sel));
    check("grant", XLEN'(grant), XLEN'(w));
    check("busy_after_req", XLEN'(busy), XLEN'(1));
    check("starve_cnt", XLEN'(dbg_starve_cnt), XLEN'(m_starve));
    if (mutate) begin
      m0_if.addr = ~a0;
      m1_if.addr = a1 ^ 32'h0000_1000;
      m0_if.sel  = ~sel0;
      m1_if.sel  = ~sel1;
    end
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      check("s_addr_held", s_if.addr, exp_addr);
      check("s_re_held", XLEN'(s_if.re), XLEN'(1));
    end
    rdata = $urandom;
    s_if.ack  = 1'b1;
    s_if.data = rdata;
    #1;
    check("m0_ack", XLEN'(m0_if.ack), XLEN'(w == 0));
    check("m1_ack", XLEN'(m1_if.ack), XLEN'(w == 1));
    check("rdata", (w == 1) ? m1_if.data : m0_if.data, rdata);
    check("s_addr_at_ack", s_if.addr, exp_addr);
    @(posedge clk); #1;
    s_if.ack = 1'b0;
    m0_if.re = 1'b0;
    m1_if.re = 1'b0;
    check("s_re_dropped", XLEN'(s_if.re), XLEN'(0));
    check("idle_after_ack", XLEN'(dbg_state), XLEN'(ARB_IDLE));
  endtask

  initial begin
    int r;
    m0_if.re = 1'b0; m0_if.sel = '0; m0_if.addr = '0;
    m1_if.re = 1'b0; m1_if.sel = '0; m1_if.addr = '0;
    s_if.ack = 1'b0; s_if.data = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_re", XLEN'(s_if.re), XLEN'(0));
    check("rst_s_addr", s_if.addr, XLEN'(0));
    check("rst_s_sel", XLEN'(s_if.sel), XLEN'(0));
    check("rst_grant", XLEN'(grant), XLEN'(0));
    check("rst_busy", XLEN'(busy), XLEN'(0));
    check("rst_starve", XLEN'(dbg_starve_cnt), XLEN'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // stray s_ack while idle
    s_if.ack = 1'b1; s_if.data = 32'hdead_beef;
    #1;
    check("stray_m0_ack", XLEN'(m0_if.ack), XLEN'(0));
    check("stray_m1_ack", XLEN'(m1_if.ack), XLEN'(0));
    @(posedge clk); #1;
    s_if.ack = 1'b0;
    check("stray_busy", XLEN'(busy), XLEN'(0));

    // single fetch, ack two cycles after s_re rises
    do_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 1'b0);
    // tie with m1 address changing while busy, then fetch alone
    do_txn(1'b1, 1'b1, 32'h0000_0100, 32'h0000_2000, 2, 1'b1);
    do_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 1'b0);
    // both requesting continuously: starvation guard (or alternation in round-robin mode)
    for (int k = 0; k < 6; k++)
      do_txn(1'b1, 1'b1, 32'h0000_1000 + 32'(k), 32'h0000_8000 + 32'(k), 0, 1'b0);

    // randomized rounds
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(1, 3);
      do_txn(r[0], r[1], $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #0;
    end

    // reset while a read is outstanding, then a late s_ack
    m1_if.re = 1'b1; m1_if.addr = 32'h0000_4000; m1_if.sel = '1;
    @(posedge clk); #1;
    check("abort_busy_pre", XLEN'(busy), XLEN'(1));
    reset = 1'b1;
    model_reset();
    #1;
    check("abort_s_re", XLEN'(s_if.re), XLEN'(0));
    check("abort_state", XLEN'(dbg_state), XLEN'(ARB_IDLE));
    m1_if.re = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    s_if.ack = 1'b1;
    #1;
    check("late_m0_ack", XLEN'(m0_if.ack), XLEN'(0));
    check("late_m1_ack", XLEN'(m1_if.ack), XLEN'(0));
    @(posedge clk); #1;
    s_if.ack = 1'b0;
    check("late_busy", XLEN'(busy), XLEN'(0));
    check("late_s_re", XLEN'(s_if.re), XLEN'(0));

    // recovery after reset: tie resolved from reset pointers
    do_txn(1'b1, 1'b1, 32'h0000_0200, 32'h0000_3000, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
